// File: rtl/stack_engine.sv
// stack_engine: multi-cycle PUSH/POP sequencer for register lists on a
// full-descending, word-addressed stack. It samples SP at start, moves one
// register per step between the register file and data memory, and then
// returns the updated SP through a one-cycle write strobe.
//
// Handshake: start is a one-cycle request that is honoured only while busy is
// low. done pulses for one cycle when the operation ends, and err pulses with
// it on a misaligned SP. The next start can be accepted in the cycle after done.
module stack_engine #(
  parameter int DATA_W     = 32,
  parameter int WORD_BYTES = 4,
  parameter int NREGS      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     op,
  input  logic [NREGS-1:0]         reg_mask,
  input  logic [DATA_W-1:0]        sp_in,
  output logic [$clog2(NREGS)-1:0] gpr_rd_addr,
  input  logic [DATA_W-1:0]        gpr_rd_data,
  output logic                     gpr_wr_en,
  output logic [$clog2(NREGS)-1:0] gpr_wr_addr,
  output logic [DATA_W-1:0]        gpr_wr_data,
  output logic [DATA_W-1:0]        mem_addr,
  output logic                     mem_wr_en,
  output logic [DATA_W-1:0]        mem_wr_data,
  output logic                     mem_rd_en,
  input  logic [DATA_W-1:0]        mem_rd_data,
  output logic                     wr_sp,
  output logic [DATA_W-1:0]        wr_sp_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [2:0]               dbg_state
);
  localparam int IDX_W = $clog2(NREGS);
  localparam logic [DATA_W-1:0] STEP = DATA_W'(WORD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH    = 3'd1,
    S_POP_REQ = 3'd2,
    S_POP_WB  = 3'd3,
    S_COMMIT  = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t             state;
  logic [NREGS-1:0]   mask_q;
  logic [DATA_W-1:0]  sp_work;
  logic [IDX_W-1:0]   hi_idx;
  logic [IDX_W-1:0]   lo_idx;
  logic [NREGS-1:0]   mask_hi_clr;
  logic [NREGS-1:0]   mask_lo_clr;

  // Select the next register: the highest remaining bit for PUSH and the
  // lowest remaining bit for POP, plus the mask with that bit removed.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (mask_q[i]) hi_idx = IDX_W'(i);
    end
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (mask_q[i]) lo_idx = IDX_W'(i);
    end
    mask_hi_clr = mask_q & ~(NREGS'(1) << hi_idx);
    mask_lo_clr = mask_q & ~(NREGS'(1) << lo_idx);
  end

  // Sequencer state, the working SP and the remaining register mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      mask_q  <= '0;
      sp_work <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q  <= reg_mask;
            sp_work <= sp_in;
            if (sp_in[1:0] != 2'b00)   state <= S_FAULT;
            else if (reg_mask == '0)   state <= S_COMMIT;
            else if (op)               state <= S_POP_REQ;
            else                       state <= S_PUSH;
          end
        end
        S_PUSH: begin
          sp_work <= sp_work - STEP;
          mask_q  <= mask_hi_clr;
          if (mask_hi_clr == '0) state <= S_COMMIT;
        end
        S_POP_REQ: state <= S_POP_WB;
        S_POP_WB: begin
          sp_work <= sp_work + STEP;
          mask_q  <= mask_lo_clr;
          state   <= (mask_lo_clr == '0) ? S_COMMIT : S_POP_REQ;
        end
        S_COMMIT: state <= S_IDLE;
        S_FAULT:  state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Output decode from the registered state; every output is zero in IDLE.
  always_comb begin
    gpr_rd_addr = '0;
    gpr_wr_en   = 1'b0;
    gpr_wr_addr = '0;
    gpr_wr_data = '0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    mem_rd_en   = 1'b0;
    wr_sp       = 1'b0;
    wr_sp_data  = '0;
    done        = 1'b0;
    err         = 1'b0;
    busy        = (state != S_IDLE);
    dbg_state   = state;
    case (state)
      S_PUSH: begin
        gpr_rd_addr = hi_idx;
        mem_addr    = sp_work - STEP;
        mem_wr_en   = 1'b1;
        mem_wr_data = gpr_rd_data;
      end
      S_POP_REQ: begin
        mem_rd_en = 1'b1;
        mem_addr  = sp_work;
      end
      S_POP_WB: begin
        gpr_wr_en   = 1'b1;
        gpr_wr_addr = lo_idx;
        gpr_wr_data = mem_rd_data;
      end
      S_COMMIT: begin
        wr_sp      = 1'b1;
        wr_sp_data = sp_work;
        done       = 1'b1;
      end
      S_FAULT: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Multi-cycle PUSH/POP sequencer for register lists on a full-descending, word-addressed stack.
- Acts as the writer side of the special-register SP port: samples SP at start, performs memory transfers, then commits the new SP back with a one-cycle write strobe.
- Sits between decode, the general register file, data memory and the special register block's SP write port.

Parameters:
- DATA_W, 32, width of registers, memory data and SP.
- WORD_BYTES, 4, SP decrement/increment per register transferred.
- NREGS, 8, number of general registers addressable by reg_mask (index width is 3).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  1  0 = PUSH, 1 = POP; captured with start.
- reg_mask  in  8  bit i set means register Ri is transferred; captured with start.
- sp_in  in  32  current SP from the special register block; captured with start.
- gpr_rd_addr  out  3  register file read index during PUSH.
- gpr_rd_data  in  32  combinational read data for gpr_rd_addr, same cycle.
- gpr_wr_en  out  1  register file write strobe during POP.
- gpr_wr_addr  out  3  register file write index.
- gpr_wr_data  out  32  register file write data.
- mem_addr  out  32  data memory byte address.
- mem_wr_en  out  1  memory store strobe.
- mem_wr_data  out  32  store data.
- mem_rd_en  out  1  memory load strobe.
- mem_rd_data  in  32  load data, valid exactly 1 cycle after mem_rd_en.
- wr_sp  out  1  one-cycle SP commit strobe.
- wr_sp_data  out  32  new SP value, valid while wr_sp = 1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.

Behaviour:
- Reset value of every output is 0; state returns to IDLE.
- Reset mid-operation aborts the operation: no wr_sp and no further memory or register strobes.
- Memory and register writes already issued before the reset are not undone.
- States: IDLE, PUSH, POP_REQ, POP_WB, COMMIT, FAULT.
- IDLE with start = 1 captures op, reg_mask and sp_in into sp_work, then:
  - sp_in[1:0] != 0 goes to FAULT.
  - reg_mask == 0 goes to COMMIT.
  - otherwise goes to PUSH or POP_REQ.
- start is ignored while busy = 1.
- PUSH order is highest set index first, one register per cycle:
  - gpr_rd_addr = idx, mem_addr = sp_work - 4, mem_wr_en = 1, mem_wr_data = gpr_rd_data.
  - sp_work -= 4; clear the bit; go to COMMIT after the last bit.
- POP order is lowest set index first, two cycles per register:
  - POP_REQ: mem_rd_en = 1, mem_addr = sp_work.
  - POP_WB: gpr_wr_en = 1, gpr_wr_addr = idx, gpr_wr_data = mem_rd_data; sp_work += 4; clear the bit.
  - After the last bit go to COMMIT, otherwise back to POP_REQ.
- Address arithmetic is modulo 2^32, with wrap-around permitted and not flagged.
- COMMIT lasts one cycle: wr_sp = 1, wr_sp_data = sp_work, done = 1, then IDLE.
  - An empty mask still commits the unchanged SP.
- FAULT lasts one cycle: done = 1, err = 1, wr_sp = 0, no memory or register activity, then IDLE.
- Latency from the start cycle to the done cycle:
  - PUSH with n registers: n + 1 cycles.
  - POP with n registers: 2n + 1 cycles.
  - Empty mask: 1 cycle.
  - Fault: 1 cycle.
- The earliest next accepted start is the cycle after done.
- mem_wr_en and mem_rd_en are never high in the same cycle.
- gpr_wr_en is high only in POP_WB.

Test Plan:
- PUSH, mask 0x0A (R1, R3), sp_in 0x100 -> cycle 1 stores R3 at 0xFC; cycle 2 stores R1 at 0xF8; cycle 3 wr_sp = 1, wr_sp_data 0xF8, done = 1.
- POP, mask 0x0A, sp_in 0xF8, memory [0xF8] = 0x11 and [0xFC] = 0x33 -> R1 = 0x11, then R3 = 0x33; wr_sp_data 0x100; done on cycle 5.
- POP, mask 0xFF, sp_in 0x0 -> 8 loads at 0x0 through 0x1C in ascending register order; wr_sp_data 0x20; done on cycle 17.
- sp_in 0x102 with start -> next cycle done = 1, err = 1; no wr_sp, mem_*_en or gpr_wr_en ever asserted.
- Empty mask, sp_in 0x200 -> next cycle wr_sp = 1, wr_sp_data 0x200, done = 1; no memory access.
- PUSH mask 0xFF, reset asserted on cycle 3 -> all outputs 0 the following cycle; wr_sp never pulses; a new start after reset is accepted.
- Second start asserted while busy -> ignored; the first operation's results are unchanged.
